// File: rtl/data_memory_mmio.sv
// ============================================================================
// Module      : data_memory_mmio
// Description : Word RAM with byte-lane writes plus memory-mapped timer,
//               display-digit register and free-running SYSTICK counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_memory_mmio #(
    parameter int RAM_WORDS = 512,
    parameter int SEG_BASE  = 200,
    parameter int DIGI_W    = 12
) (
    input  logic              reset,
    input  logic              clk,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [3:0]        ByteEn,
    input  logic [31:0]       Address,
    input  logic [31:0]       Write_data,
    output logic [31:0]       Read_data,
    output logic [DIGI_W-1:0] digi,
    output logic              irq
);

    localparam int          AW         = $clog2(RAM_WORDS);
    localparam logic [31:0] c_addr_th   = 32'h4000_0000;
    localparam logic [31:0] c_addr_tl   = 32'h4000_0004;
    localparam logic [31:0] c_addr_tcon = 32'h4000_0008;
    localparam logic [31:0] c_addr_digi = 32'h4000_0010;
    localparam logic [31:0] c_addr_tick = 32'h4000_0014;
    localparam logic [0:0]  c_tmr_idle  = 1'b0;
    localparam logic [0:0]  c_tmr_count = 1'b1;

    function automatic logic [7:0] seg_code(input logic [3:0] k);
        case (k)
            4'h0: seg_code = 8'h3F;  4'h1: seg_code = 8'h06;
            4'h2: seg_code = 8'h5B;  4'h3: seg_code = 8'h4F;
            4'h4: seg_code = 8'h66;  4'h5: seg_code = 8'h6D;
            4'h6: seg_code = 8'h7D;  4'h7: seg_code = 8'h07;
            4'h8: seg_code = 8'h7F;  4'h9: seg_code = 8'h6F;
            4'hA: seg_code = 8'h77;  4'hB: seg_code = 8'h7C;
            4'hC: seg_code = 8'h39;  4'hD: seg_code = 8'h5E;
            4'hE: seg_code = 8'h79;  default: seg_code = 8'h71;
        endcase
    endfunction

    logic [31:0]       r_ram [RAM_WORDS];
    logic [31:0]       r_th;
    logic [31:0]       r_tl;
    logic [2:0]        r_tcon;
    logic [31:0]       r_systick;
    logic [DIGI_W-1:0] r_digi;

    logic [AW-1:0] w_idx;
    logic          w_sel_ram, w_sel_th, w_sel_tl, w_sel_tcon, w_sel_digi, w_sel_tick;
    logic          w_ovf;
    logic [31:0]   w_tl_next;
    logic [2:0]    w_tcon_next;
    logic          w_unused_addr;

    // Byte offset bits never participate in decoding
    assign w_unused_addr = ^Address[1:0];

    assign w_idx      = Address[AW+1:2];
    assign w_sel_ram  = (Address[31:28] == 4'h0);
    assign w_sel_th   = (Address[31:2] == c_addr_th[31:2]);
    assign w_sel_tl   = (Address[31:2] == c_addr_tl[31:2]);
    assign w_sel_tcon = (Address[31:2] == c_addr_tcon[31:2]);
    assign w_sel_digi = (Address[31:2] == c_addr_digi[31:2]);
    assign w_sel_tick = (Address[31:2] == c_addr_tick[31:2]);

    always_comb begin
        Read_data = 32'h0;
        if (MemRead) begin
            if (w_sel_ram)       Read_data = r_ram[w_idx];
            else if (w_sel_th)   Read_data = r_th;
            else if (w_sel_tl)   Read_data = r_tl;
            else if (w_sel_tcon) Read_data = {29'h0, r_tcon};
            else if (w_sel_digi) Read_data = 32'(r_digi);
            else if (w_sel_tick) Read_data = r_systick;
        end
    end

    // Overflow is the last counting cycle before reload from TH
    assign w_ovf = (r_tcon[0] == c_tmr_count) && (r_tl == 32'hFFFF_FFFF);

    always_comb begin
        w_tl_next = r_tl;
        if (MemWrite && w_sel_tl)
            w_tl_next = Write_data;
        else if (w_ovf)
            w_tl_next = r_th;
        else if (r_tcon[0] != c_tmr_idle)
            w_tl_next = r_tl + 32'd1;

        w_tcon_next = r_tcon;
        if (MemWrite && w_sel_tcon)
            w_tcon_next = Write_data[2:0];
        if (w_ovf && r_tcon[1])
            w_tcon_next[2] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RAM_WORDS; i++) begin
                if (i >= SEG_BASE && i < SEG_BASE + 16)
                    r_ram[i] <= {24'h0, seg_code(4'(i - SEG_BASE))};
                else
                    r_ram[i] <= 32'h0;
            end
        end else if (MemWrite && w_sel_ram) begin
            for (int b = 0; b < 4; b++) begin
                if (ByteEn[b])
                    r_ram[w_idx][8*b +: 8] <= Write_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_th      <= 32'h0;
            r_tl      <= 32'h0;
            r_tcon    <= 3'h0;
            r_systick <= 32'h0;
            r_digi    <= '0;
        end else begin
            r_systick <= r_systick + 32'd1;
            r_tl      <= w_tl_next;
            r_tcon    <= w_tcon_next;
            if (MemWrite && w_sel_th)
                r_th <= Write_data;
            if (MemWrite && w_sel_digi)
                r_digi <= Write_data[DIGI_W-1:0];
        end
    end

    assign digi = r_digi;
    assign irq  = r_tcon[2] & r_tcon[1];

endmodule

`default_nettype wire

// File: tb/tb_data_memory_mmio.sv
// ============================================================================
// Module      : tb_data_memory_mmio
// Description : Directed stimulus for data_memory_mmio checked against a
//               behavioural memory/timer model and literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_memory_mmio;

    localparam int RAM_WORDS = 512;
    localparam int SEG_BASE  = 200;
    localparam int DIGI_W    = 12;
    localparam int AW        = $clog2(RAM_WORDS);

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_DIGI = 32'h4000_0010;
    localparam logic [31:0] A_TICK = 32'h4000_0014;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              MemRead = 1'b0;
    logic              MemWrite = 1'b0;
    logic [3:0]        ByteEn = 4'h0;
    logic [31:0]       Address = 32'h0;
    logic [31:0]       Write_data = 32'h0;
    logic [31:0]       Read_data;
    logic [DIGI_W-1:0] digi;
    logic              irq;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    data_memory_mmio #(.RAM_WORDS(RAM_WORDS), .SEG_BASE(SEG_BASE), .DIGI_W(DIGI_W)) dut (
        .reset(reset), .clk(clk), .MemRead(MemRead), .MemWrite(MemWrite),
        .ByteEn(ByteEn), .Address(Address), .Write_data(Write_data),
        .Read_data(Read_data), .digi(digi), .irq(irq)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [31:0]       m_ram [RAM_WORDS];
    logic [31:0]       m_th, m_tl, m_systick;
    logic [2:0]        m_tcon;
    logic [DIGI_W-1:0] m_digi;
    logic [7:0]        seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    function automatic logic [31:0] model_read(input logic rd, input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (!rd)                 return 32'h0;
        if (a[31:28] == 4'h0)    return m_ram[a[AW+1:2]];
        if (wa == A_TH)          return m_th;
        if (wa == A_TL)          return m_tl;
        if (wa == A_TCON)        return {29'h0, m_tcon};
        if (wa == A_DIGI)        return 32'(m_digi);
        if (wa == A_TICK)        return m_systick;
        return 32'h0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RAM_WORDS; i++)
                m_ram[i] <= (i >= SEG_BASE && i < SEG_BASE + 16) ? 32'(seg_tab[i - SEG_BASE]) : 32'h0;
            m_th <= 0; m_tl <= 0; m_tcon <= 0; m_systick <= 0; m_digi <= 0;
        end else begin
            m_systick <= m_systick + 1;
            if (MemWrite && Address[31:28] == 4'h0)
                for (int b = 0; b < 4; b++)
                    if (ByteEn[b]) m_ram[Address[AW+1:2]][8*b +: 8] <= Write_data[8*b +: 8];
            if (MemWrite && {Address[31:2], 2'b00} == A_TH) m_th <= Write_data;
            if (MemWrite && {Address[31:2], 2'b00} == A_DIGI) m_digi <= Write_data[DIGI_W-1:0];
            if (MemWrite && {Address[31:2], 2'b00} == A_TL) m_tl <= Write_data;
            else if (m_tcon[0]) m_tl <= (m_tl == 32'hFFFF_FFFF) ? m_th : m_tl + 1;
            if (MemWrite && {Address[31:2], 2'b00} == A_TCON)
                m_tcon <= {Write_data[2] | (m_tcon[0] & m_tcon[1] & (m_tl == 32'hFFFF_FFFF)), Write_data[1:0]};
            else
                m_tcon <= {m_tcon[2] | (m_tcon[0] & m_tcon[1] & (m_tl == 32'hFFFF_FFFF)), m_tcon[1:0]};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            chk("mon_rdata", Read_data, model_read(MemRead, Address));
            chk("mon_digi", 32'(digi), 32'(m_digi));
            chk("mon_irq", 32'(irq), 32'(m_tcon[2] & m_tcon[1]));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        MemWrite = 1'b1; MemRead = 1'b0; Address = a; Write_data = d; ByteEn = be;
        tick();
        MemWrite = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        MemRead = 1'b1; Address = a;
        #2;
        chk(name, Read_data, exp);
    endtask

    initial begin
        #1 reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        mon_en = 1'b1;

        rd_chk("rst_seg10", 32'((SEG_BASE + 10) * 4), 32'h0000_0077);
        rd_chk("rst_seg0", 32'(SEG_BASE * 4), 32'h0000_003F);
        rd_chk("rst_word0", 32'h0, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_digi", 32'(digi), 32'h0);
        MemRead = 1'b0;
        #1 chk("rd_disabled", Read_data, 32'h0);

        wr(32'h10, 32'hAABB_CCDD, 4'hF);
        wr(32'h10, 32'h1122_3344, 4'h5);
        rd_chk("byte_lanes", 32'h10, 32'hAA22_CC44);
        wr(32'h10, 32'hFFFF_FFFF, 4'h0);
        rd_chk("be_zero", 32'h10, 32'hAA22_CC44);
        rd_chk("alias", 32'h0000_0810, 32'hAA22_CC44);
        rd_chk("hi_nibble_unmapped", 32'h1000_0010, 32'h0);

        MemRead = 1'b1; MemWrite = 1'b1; Address = 32'h10;
        Write_data = 32'h5566_7788; ByteEn = 4'hF;
        #2 chk("rw_same_old", Read_data, 32'hAA22_CC44);
        tick(); MemWrite = 1'b0;
        rd_chk("rw_same_new", 32'h10, 32'h5566_7788);

        wr(A_TH, 32'hFFFF_FFFD, 4'h0);
        wr(A_TL, 32'hFFFF_FFFE, 4'h0);
        wr(A_TCON, 32'h3, 4'h0);
        rd_chk("tl_start", A_TL, 32'hFFFF_FFFE);
        tick(); rd_chk("tl_inc", A_TL, 32'hFFFF_FFFF);
        chk("irq_before_ovf", 32'(irq), 32'h0);
        tick(); rd_chk("tl_reload", A_TL, 32'hFFFF_FFFD);
        chk("irq_rise", 32'(irq), 32'h1);
        tick(); rd_chk("tl_after_reload", A_TL, 32'hFFFF_FFFE);
        wr(A_TCON, 32'h3, 4'h0);
        chk("irq_cleared", 32'(irq), 32'h0);
        wr(A_TCON, 32'h3, 4'h0);
        rd_chk("tcon_ovf_wins", A_TCON, 32'h7);
        chk("irq_held", 32'(irq), 32'h1);
        wr(A_TL, 32'h0000_1000, 4'h0);
        rd_chk("tl_write_wins", A_TL, 32'h0000_1000);
        wr(A_TCON, 32'h0, 4'h0);

        wr(A_DIGI, 32'h0000_0ABC, 4'h0);
        chk("digi_write", 32'(digi), 32'h0000_0ABC);
        rd_chk("ram_untouched", 32'h10, 32'h5566_7788);
        wr(A_TICK, 32'h0, 4'hF);
        rd_chk("systick_ro", A_TICK, m_systick);
        rd_chk("unmapped_rd", 32'h4000_0020, 32'h0);
        wr(32'h4000_0020, 32'hDEAD_BEEF, 4'hF);
        rd_chk("unmapped_wr", 32'h4000_0020, 32'h0);

        wr(32'(SEG_BASE * 4), 32'h0000_DEAD, 4'hF);
        rd_chk("seg_corrupt", 32'(SEG_BASE * 4), 32'h0000_DEAD);
        wr(A_TL, 32'h0000_1234, 4'h0);
        wr(A_TCON, 32'h3, 4'h0);
        MemRead = 1'b1; Address = A_TL;
        #1 reset = 1'b1;
        #1 chk("rst_tl", Read_data, 32'h0);
        chk("rst_irq_mid", 32'(irq), 32'h0);
        chk("rst_digi_mid", 32'(digi), 32'h0);
        Address = A_TCON;
        #1 chk("rst_tcon", Read_data, 32'h0);
        Address = 32'(SEG_BASE * 4);
        #1 chk("rst_seg_restored", Read_data, 32'h0000_003F);
        tick();
        reset = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/data_memory_mmio.md
DATA_MEMORY_MMIO -- requirements
Module: data_memory_mmio

Interface
REQ-001 Parameter RAM_WORDS, default 512, number of 32-bit RAM words; power of two, 64..4096.
REQ-002 Parameter SEG_BASE, default 200, word index of the 16-entry seven-segment code table; SEG_BASE+16 <= RAM_WORDS.
REQ-003 Parameter DIGI_W, default 12, width of the display-digit register.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 clk  input  1  clock; all state changes on its rising edge.
REQ-006 MemRead  input  1  read enable.
REQ-007 MemWrite  input  1  write enable.
REQ-008 ByteEn  input  4  write byte lanes; bit n enables Write_data[8n+7:8n].
REQ-009 Address  input  32  byte address; bits [1:0] ignored.
REQ-010 Write_data  input  32  store data.
REQ-011 Read_data  output  32  load data, combinational.
REQ-012 digi  output  DIGI_W  display-digit register.
REQ-013 irq  output  1  timer interrupt request, equal to TCON[2] & TCON[1].

Function
REQ-014 RAM region: Address[31:28]==0 and word index Address[AW+1:2] < RAM_WORDS, where AW=log2(RAM_WORDS); Address bits [27:AW+2] shall be ignored, so higher addresses alias.
REQ-015 MMIO map: 0x40000000 TH, 0x40000004 TL, 0x40000008 TCON[2:0], 0x40000010 digi, 0x40000014 SYSTICK; any other address is unmapped.
REQ-016 Read_data shall be 0 when MemRead=0 or the address is unmapped; otherwise the addressed word zero-extended, same-cycle combinational (zero latency).
REQ-017 RAM write: on MemWrite, only lanes with ByteEn set are updated; ByteEn=0000 shall leave memory unchanged.
REQ-018 MMIO writes shall ignore ByteEn and write the full register; TCON keeps Write_data[2:0], digi keeps Write_data[DIGI_W-1:0]; SYSTICK is read-only, and writes to it are dropped.
REQ-019 Writes to unmapped addresses shall have no effect.
REQ-020 SYSTICK shall increment by 1 every cycle out of reset and wrap from 0xFFFFFFFF to 0.
REQ-021 Timer states: IDLE (TCON[0]=0), TL holds its value; COUNT (TCON[0]=1), TL increments by 1 per cycle.
REQ-022 In COUNT with TL==0xFFFFFFFF, the next TL shall be TH (reload), and TCON[2] shall be set if TCON[1]=1.
REQ-023 A CPU write to TL in the same cycle as an increment or reload shall take priority.
REQ-024 TCON[2] set by overflow shall take priority over a same-cycle CPU write clearing it; TCON[1:0] shall take the written value.
REQ-025 A read of any register shall return its pre-edge value, with no read side effects.
REQ-026 Simultaneous MemRead and MemWrite to the same address shall return the old data on Read_data.

Reset
REQ-027 On reset assertion, asynchronously: RAM[SEG_BASE+k] = seg code k for k=0..15 (3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 hex, zero-extended); all other RAM words 0.
REQ-028 On reset assertion, TH, TL, TCON, SYSTICK, digi and irq shall be 0.
REQ-029 Reset asserted mid-count or mid-write shall override all activity; no write shall complete in a cycle where reset is high.

Verification
REQ-030 Reset, read word SEG_BASE+10 -> Read_data=0x00000077; read word 0 -> 0; irq=0, digi=0.
REQ-031 Write 0xAABBCCDD to word 4 with ByteEn=1111, then 0x11223344 with ByteEn=0101 -> read returns 0xAA22CC44.
REQ-032 TH=0xFFFFFFFD, TL=0xFFFFFFFE, TCON=011 -> TL goes FFFFFFFF, FFFFFFFD, FFFFFFFE; irq rises the cycle after TL=FFFFFFFF; writing TCON=011 clears irq.
REQ-033 Overflow cycle coinciding with a TCON=011 write -> TCON reads 111, irq stays 1; TL write coinciding with increment -> TL equals the written value.
REQ-034 Write 0x00000ABC to 0x40000010 -> digi=0xABC, RAM unchanged; write to 0x40000014 -> SYSTICK unaffected; read of 0x40000020 -> 0.
REQ-035 Assert reset mid-count with TL=0x1234 -> TL, TCON, irq = 0 immediately, and the seg table is restored.
